// File: rtl/fifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
// Write-side pointer and flag controller of an asynchronous FIFO (W_CLK
// domain). Keeps the binary write pointer, publishes a registered Gray write
// pointer to the read domain, synchronizes the read domain's Gray pointer
// back through two flops and derives full / almost-full / level / overflow.
//
// Ports
//   W_CLK          in   write-domain clock
//   W_RST          in   asynchronous active-low reset
//   Winc           in   write request from the producer
//   R_ptr_gray     in   read-domain Gray pointer (asynchronous to W_CLK)
//   W_addr         out  memory write address {1'b0, wbin[P_SIZE-2:0]}
//   W_ptr_gray     out  registered Gray write pointer
//   Wfull          out  FIFO full; memory writes are gated by Winc & !Wfull
//   W_almost_full  out  registered, fill level >= AF_THR
//   W_level        out  registered fill level 0..DEPTH seen from write side
//   W_ovf          out  sticky overflow, set by a write attempt while full
// ---------------------------------------------------------------------------
module fifo_wr_ptr_ctrl #(
  parameter int DEPTH  = 8,
  parameter int P_SIZE = 4,
  parameter int AF_THR = 6
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              Winc,
  input  logic [P_SIZE-1:0] R_ptr_gray,
  output logic [P_SIZE-1:0] W_addr,
  output logic [P_SIZE-1:0] W_ptr_gray,
  output logic              Wfull,
  output logic              W_almost_full,
  output logic [P_SIZE-1:0] W_level,
  output logic              W_ovf
);

  localparam logic [P_SIZE-1:0] AF_THR_P = AF_THR[P_SIZE-1:0];

  logic [P_SIZE-1:0] r_wbin;
  logic [P_SIZE-1:0] r_wgray;
  logic [P_SIZE-1:0] r_rq1;
  logic [P_SIZE-1:0] r_rq2;
  logic              r_full;
  logic              r_af;
  logic [P_SIZE-1:0] r_level;
  logic              r_ovf;

  logic              w_wen;
  logic [P_SIZE-1:0] w_wbin_next;
  logic [P_SIZE-1:0] w_wgray_next;
  logic [P_SIZE-1:0] w_rbin_s;
  logic [P_SIZE-1:0] w_level_next;
  logic [P_SIZE-1:0] w_full_cmp;
  logic              w_full_next;

  assign w_wen        = Winc & ~r_full;
  assign w_wbin_next  = r_wbin + P_SIZE'(w_wen);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  // Gray-to-binary of the synchronized read pointer: XOR prefix from the MSB.
  assign w_rbin_s[P_SIZE-1] = r_rq2[P_SIZE-1];
  generate
    for (genvar gi = P_SIZE - 2; gi >= 0; gi--) begin : g_g2b
      assign w_rbin_s[gi] = w_rbin_s[gi+1] ^ r_rq2[gi];
    end
  endgenerate

  // Full when the next write pointer is exactly one lap ahead of the
  // synchronized read pointer: in Gray code that means the top two bits
  // are inverted and the rest equal.
  assign w_full_cmp   = {~r_rq2[P_SIZE-1:P_SIZE-2], r_rq2[P_SIZE-3:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_level_next = w_wbin_next - w_rbin_s;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_rq1   <= R_ptr_gray;
      r_rq2   <= r_rq1;
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_af    <= (w_level_next >= AF_THR_P);
      r_level <= w_level_next;
      // Sticky until reset; the pointer itself is held by w_wen.
      if (Winc & r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign W_addr        = {1'b0, r_wbin[P_SIZE-2:0]};
  assign W_ptr_gray    = r_wgray;
  assign Wfull         = r_full;
  assign W_almost_full = r_af;
  assign W_level       = r_level;
  assign W_ovf         = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
module tb_fifo_wr_ptr_ctrl;

  localparam int DEPTH  = 8;
  localparam int P_SIZE = 4;
  localparam int AF_THR = 6;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       Winc = 1'b0;
  logic [3:0] R_ptr_gray = 4'd0;
  logic [3:0] W_addr;
  logic [3:0] W_ptr_gray;
  logic       Wfull;
  logic       W_almost_full;
  logic [3:0] W_level;
  logic       W_ovf;

  int checks = 0;
  int errors = 0;

  fifo_wr_ptr_ctrl #(.DEPTH(DEPTH), .P_SIZE(P_SIZE), .AF_THR(AF_THR)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .Winc(Winc), .R_ptr_gray(R_ptr_gray),
    .W_addr(W_addr), .W_ptr_gray(W_ptr_gray), .Wfull(Wfull),
    .W_almost_full(W_almost_full), .W_level(W_level), .W_ovf(W_ovf)
  );

  always #5 W_CLK = ~W_CLK;

  // Reference model in terms of write/read counts.
  int m_wr, m_rd, m_rq1, m_rq2, m_lvl;
  bit m_full, m_af, m_ovf;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_rq1 = 0; m_rq2 = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // Drive inputs for one edge, advance the model, sample #1 after the edge.
  task automatic step(input bit winc, input int rd);
    bit acc;
    Winc = winc;
    m_rd = rd;
    R_ptr_gray = gray4(rd);
    @(posedge W_CLK);
    acc = winc && !m_full;
    if (winc && m_full) m_ovf = 1;
    if (acc) m_wr++;
    m_lvl = m_wr - m_rq2;
    m_full = (m_lvl == DEPTH);
    m_af = (m_lvl >= AF_THR);
    m_rq2 = m_rq1;
    m_rq1 = m_rd;
    #1;
  endtask

  task automatic do_reset();
    W_RST = 1'b0;
    Winc = 1'b0;
    R_ptr_gray = 4'd0;
    model_reset();
    @(posedge W_CLK);
    #1;
    W_RST = 1'b1;
  endtask

  task automatic test_reset();
    W_RST = 1'b0;
    #1;
    checks++;
    if ({W_addr, W_ptr_gray, Wfull, W_almost_full, W_level, W_ovf} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b expected all 0",
               W_addr, W_ptr_gray, Wfull, W_almost_full, W_level, W_ovf);
    end
    do_reset();
    step(0, 0);
    checks++;
    if (W_addr !== 4'd0 || Wfull !== 1'b0 || W_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle got addr=%0d full=%b lvl=%0d expected 0/0/0", W_addr, Wfull, W_level);
    end
    $display("test_reset: addr=%0d full=%b lvl=%0d", W_addr, Wfull, W_level);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0);
      checks++;
      if (W_addr !== 4'(m_wr % DEPTH) || W_ptr_gray !== gray4(m_wr)) begin
        errors++;
        $display("FAIL fill_ptr[%0d] got addr=%0d gray=%b expected addr=%0d gray=%b",
                 i, W_addr, W_ptr_gray, m_wr % DEPTH, gray4(m_wr));
      end
      checks++;
      if (W_level !== 4'(i) || Wfull !== (i == 8) || W_almost_full !== (i >= 6)) begin
        errors++;
        $display("FAIL fill_flags[%0d] got lvl=%0d full=%b af=%b expected lvl=%0d full=%b af=%b",
                 i, W_level, Wfull, W_almost_full, i, (i == 8), (i >= 6));
      end
      $display("fill write %0d: addr=%0d gray=%b lvl=%0d full=%b af=%b",
               i, W_addr, W_ptr_gray, W_level, Wfull, W_almost_full);
    end
    checks++;
    if (W_ptr_gray !== 4'b1100) begin
      errors++;
      $display("FAIL fill_final_gray got %b expected 1100", W_ptr_gray);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(i < 2, 0);
      checks++;
      if (W_addr !== 4'd0 || W_ptr_gray !== 4'b1100 || W_ovf !== 1'b1 || Wfull !== 1'b1) begin
        errors++;
        $display("FAIL overflow[%0d] got addr=%0d gray=%b ovf=%b full=%b expected 0/1100/1/1",
                 i, W_addr, W_ptr_gray, W_ovf, Wfull);
      end
      $display("overflow cycle %0d: winc=%b addr=%0d ovf=%b", i, Winc, W_addr, W_ovf);
    end
  endtask

  task automatic test_drain();
    step(0, 1);
    step(0, 1);
    checks++;
    if (Wfull !== 1'b1 || W_level !== 4'd8) begin
      errors++;
      $display("FAIL drain_early got full=%b lvl=%0d expected full=1 lvl=8", Wfull, W_level);
    end
    step(0, 1);
    checks++;
    if (Wfull !== 1'b0 || W_level !== 4'd7 || W_almost_full !== 1'b1) begin
      errors++;
      $display("FAIL drain_release got full=%b lvl=%0d af=%b expected full=0 lvl=7 af=1",
               Wfull, W_level, W_almost_full);
    end
    step(1, 1);
    checks++;
    if (W_addr !== 4'd1 || Wfull !== 1'b1 || W_level !== 4'd8) begin
      errors++;
      $display("FAIL drain_write got addr=%0d full=%b lvl=%0d expected addr=1 full=1 lvl=8",
               W_addr, Wfull, W_level);
    end
    $display("drain: addr=%0d lvl=%0d full=%b", W_addr, W_level, Wfull);
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    int budget;
    int rd;
    do_reset();
    prev = W_ptr_gray;
    budget = 0;
    rd = 0;
    while (m_wr < 20 && budget < 100) begin
      if (m_wr >= 3 && rd < m_wr) rd++;
      step(1, rd);
      budget++;
      checks++;
      if ($countones(prev ^ W_ptr_gray) > 1 || W_ptr_gray !== gray4(m_wr)) begin
        errors++;
        $display("FAIL wrap_gray[%0d] got %b (prev %b) expected %b", m_wr, W_ptr_gray, prev, gray4(m_wr));
      end
      checks++;
      if (W_level !== 4'(m_lvl) || Wfull !== m_full) begin
        errors++;
        $display("FAIL wrap_level[%0d] got lvl=%0d full=%b expected lvl=%0d full=%b",
                 m_wr, W_level, Wfull, m_lvl, m_full);
      end
      if (m_wr == 8 || m_wr == 16) begin
        checks++;
        if (W_ptr_gray[3] !== 1'((m_wr / 8) % 2)) begin
          errors++;
          $display("FAIL wrap_msb[%0d] got %b expected %0d", m_wr, W_ptr_gray[3], (m_wr / 8) % 2);
        end
      end
      $display("wrap: writes=%0d reads=%0d gray=%b lvl=%0d", m_wr, rd, W_ptr_gray, W_level);
      prev = W_ptr_gray;
    end
    checks++;
    if (m_wr != 20) begin
      errors++;
      $display("FAIL wrap_budget got %0d writes expected 20", m_wr);
    end
  endtask

  task automatic test_random();
    int rd;
    do_reset();
    rd = 0;
    for (int i = 0; i < 300; i++) begin
      if (rd < m_wr && $urandom_range(0, 2) == 0) rd++;
      step(1'($urandom_range(0, 3) != 0), rd);
      checks++;
      if (W_addr !== 4'(m_wr % DEPTH) || W_ptr_gray !== gray4(m_wr) || W_level !== 4'(m_lvl) ||
          Wfull !== m_full || W_almost_full !== m_af || W_ovf !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d] got addr=%0d gray=%b lvl=%0d full=%b af=%b ovf=%b expected addr=%0d gray=%b lvl=%0d full=%b af=%b ovf=%b",
                 i, W_addr, W_ptr_gray, W_level, Wfull, W_almost_full, W_ovf,
                 m_wr % DEPTH, gray4(m_wr), m_lvl, m_full, m_af, m_ovf);
      end
      $display("random %0d: winc=%b rd=%0d addr=%0d lvl=%0d full=%b ovf=%b",
               i, Winc, rd, W_addr, W_level, Wfull, W_ovf);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    checks++;
    if (W_level !== 4'd5) begin
      errors++;
      $display("FAIL midreset_pre got lvl=%0d expected 5", W_level);
    end
    #2;
    W_RST = 1'b0;
    #1;
    checks++;
    if ({W_addr, W_ptr_gray, Wfull, W_almost_full, W_level, W_ovf} !== 15'd0) begin
      errors++;
      $display("FAIL midreset_async got addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b expected all 0",
               W_addr, W_ptr_gray, Wfull, W_almost_full, W_level, W_ovf);
    end
    $display("mid reset: addr=%0d lvl=%0d", W_addr, W_level);
    do_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
